neuron_cache_fill_control: RTL and testbench
============================================

Name: neuron_cache_fill_control

Overview:
- Upstream neighbour of the neuron fetch controller.
- Accepts the input-picture pixel stream column by column.
- Writes each column into one of the 7 neuron-cache channels (one channel = one picture column, address = row); channels are used in the same rotating order the fetch side reads them.
- Tracks filled-but-unconsumed columns, raises window_ready_o to enable fetching, and back-pressures the stream when all channels are occupied.

Parameters:
- DATA_BIT_WIDTH, 8, pixel width.
- CACHE_DEPTH_BIT_WIDTH, 5, row/address width (32 rows).
- PICTURE_WIDTH_BIT_WIDTH, 5, column counter width (32 columns).
- FILTER_WIDTH_BIT_WIDTH, 3, encoded filter width (0 means 1 wide).
- CACHE_CHANNELS, 7, number of cache channels.
- OCC_BIT_WIDTH, 3, occupancy counter width (0..7).

Ports:
- clk  in  1  clock
- layer_reset  in  1  asynchronous active-high reset; also starts a new layer
- pixel_valid_i  in  1  stream valid
- pixel_ready_o  out  1  stream ready
- pixel_data_i  in  DATA_BIT_WIDTH  pixel, column-major order (rows 0..H within a column, then next column)
- picture_height_i  in  CACHE_DEPTH_BIT_WIDTH  last row index (H)
- picture_width_i  in  PICTURE_WIDTH_BIT_WIDTH  last column index (W)
- filter_width_i  in  FILTER_WIDTH_BIT_WIDTH  encoded filter width (fw)
- column_release_i  in  1  one-cycle pulse from the fetch side when it switches away from a channel
- cache_wr_o  out  1  cache write strobe
- wr_address_o  out  CACHE_DEPTH_BIT_WIDTH  write row address
- wr_channel_sel_o  out  CACHE_CHANNELS  one-hot write channel
- wr_data_o  out  DATA_BIT_WIDTH  write data
- occupancy_o  out  OCC_BIT_WIDTH  filled, unreleased columns
- window_ready_o  out  1  fetch may run
- layer_done_o  out  1  all columns written and released
- release_err_o  out  1  sticky: release received while occupancy was 0

Behaviour:
- Reset (async, any time, including mid-column):
  - All counters 0, state FILL.
  - cache_wr_o=0, wr_address_o=0, wr_data_o=0, occupancy_o=0.
  - wr_channel_sel_o=7'b1000000.
  - window_ready_o=0, layer_done_o=0, release_err_o=0.
  - A partially written column is discarded.
- Accept = pixel_valid_i && pixel_ready_o.
- pixel_ready_o = (state==FILL) && (occupancy < CACHE_CHANNELS); combinational from registers only.
- Write path:
  - Registered, latency 1: the cycle after an accept, cache_wr_o=1 with wr_data_o = accepted pixel, wr_address_o = row counter value at accept, wr_channel_sel_o = write pointer at accept.
  - Otherwise cache_wr_o=0 and the other write outputs hold.
- Row counter:
  - Increments on accept.
  - At accept with row==H: row<=0, column completes.
- Column completion:
  - Write pointer rotates right: {sel[0], sel[6:1]}.
  - Column counter +1.
  - Occupancy +1, effective in the same cycle as the last pixel's cache write (the completion registers update on the accept edge).
- Occupancy update (one register):
  - Completion only: +1.
  - Release only: -1.
  - Both in the same cycle: unchanged.
  - Release at 0: ignored, release_err_o<=1.
- FSM:
  - FILL: accepts pixels. Moves to DRAIN when column W completes.
  - DRAIN: pixel_ready_o=0. Moves to DONE when occupancy reaches 0.
  - DONE: layer_done_o=1, ready=0. Holds until layer_reset.
- window_ready_o, registered from next-state values:
  - 1 when occupancy >= fw+1.
  - Also 1 in DRAIN with occupancy > 0 (flush tail columns).
  - Else 0.
- Width rules:
  - Occupancy compare is done in OCC_BIT_WIDTH+1 bits.
  - fw values 6–7 are illegal and are treated as fw=0.
  - H=31 uses the full depth; the row counter never exceeds H.
- Config inputs must be stable from layer_reset release to layer_done_o; changes mid-layer are undefined.

Decomposition:
- Shared package (neuron_cache_pkg) holds:
  - Widths: DATA, CACHE_DEPTH, FILTER_WIDTH.
  - CACHE_CHANNELS and CHANNEL_SEL_INIT=7'b1000000.
  - Filter-width encodings FILTER_WIDTH_1..6.
  - The rotate-right channel function, shared with the fetch controller so both sides rotate identically.
- One sub-module: neuron_cache_occupancy. It holds the up/down counter, the simultaneous-event rule, release_err_o and the window_ready compare.

Test Plan:
- H=3, W=2, fw=1, no release: 12 accepts → writes to channels 1000000, 0100000, 0010000 at rows 0-3, each 1 cycle after accept. window_ready_o=1 after column 1 completes; occupancy 3 at end; state DRAIN, ready=0.
- H=0, W=9, fw=0, no release: 7 accepts fill occupancy to 7, pixel_ready_o=0. One release pulse → occupancy 6, ready=1; the next write selects channel 1000000 (wrapped).
- Simultaneous: occupancy 7 reached, one release (ready=1), then last-pixel accept in the same cycle as a second release pulse → occupancy stays at the prior value. Release at occupancy 0 → release_err_o=1 and stays set.
- Drain: W=3, fw=5, 4 columns written → window_ready_o=1 in DRAIN despite occupancy 4<6. 4 releases → layer_done_o=1 the cycle after occupancy reaches 0.
- Reset mid-column: assert layer_reset after row 2 of column 1 → all outputs to reset values immediately (async). A restart writes row 0 to channel 1000000.
- Back-pressure: valid held high with random ready stalls → no pixel is duplicated or dropped; address sequence 0..H per channel is checked against a scoreboard.

Source files
------------

// File: rtl/neuron_cache_pkg.sv
// Shared widths, channel encodings and the channel rotation helper for the
// neuron-cache fill and fetch controllers.
package neuron_cache_pkg;

    localparam int DATA_BIT_WIDTH          = 8;
    localparam int CACHE_DEPTH_BIT_WIDTH   = 5;
    localparam int PICTURE_WIDTH_BIT_WIDTH = 5;
    localparam int FILTER_WIDTH_BIT_WIDTH  = 3;
    localparam int CACHE_CHANNELS          = 7;
    localparam int OCC_BIT_WIDTH           = 3;

    localparam logic [CACHE_CHANNELS-1:0] CHANNEL_SEL_INIT = 7'b1000000;

    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_1 = 3'd0;
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_2 = 3'd1;
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_3 = 3'd2;
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_4 = 3'd3;
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_5 = 3'd4;
    localparam logic [FILTER_WIDTH_BIT_WIDTH-1:0] FILTER_WIDTH_6 = 3'd5;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fill_state_t;

    // Fetch side uses the same rotation, so both walk the channels in step.
    function automatic logic [CACHE_CHANNELS-1:0] rotate_channel(
        input logic [CACHE_CHANNELS-1:0] sel
    );
        return {sel[0], sel[CACHE_CHANNELS-1:1]};
    endfunction

endpackage

// File: rtl/neuron_cache_occupancy.sv
// Counts filled-but-unreleased cache columns and decides when the fetch side
// has enough columns buffered to run.
module neuron_cache_occupancy
    import neuron_cache_pkg::*;
(
    input  logic                              clk,
    input  logic                              layer_reset,
    input  logic                              column_done,
    input  logic                              column_release,
    input  logic                              drain_next,
    input  logic [FILTER_WIDTH_BIT_WIDTH-1:0] filter_width,
    output logic [OCC_BIT_WIDTH-1:0]          occupancy,
    output logic                              window_ready,
    output logic                              release_err
);

    localparam logic [OCC_BIT_WIDTH-1:0] OCC_ONE  = OCC_BIT_WIDTH'(1);
    localparam logic [OCC_BIT_WIDTH:0]   WIDE_ONE = (OCC_BIT_WIDTH+1)'(1);

    logic [OCC_BIT_WIDTH-1:0]          occ_next;
    logic [FILTER_WIDTH_BIT_WIDTH-1:0] fw_eff;
    logic [OCC_BIT_WIDTH:0]            window_need;
    logic                              release_at_zero;

    // A completion and a release in the same cycle cancel out.
    always_comb begin
        occ_next        = occupancy;
        release_at_zero = 1'b0;
        if (column_done && !column_release) begin
            occ_next = occupancy + OCC_ONE;
        end else if (column_release && !column_done) begin
            if (occupancy == '0) begin
                release_at_zero = 1'b1;
            end else begin
                occ_next = occupancy - OCC_ONE;
            end
        end
    end

    assign fw_eff      = (filter_width > FILTER_WIDTH_6) ? FILTER_WIDTH_1 : filter_width;
    assign window_need = (OCC_BIT_WIDTH+1)'(fw_eff) + WIDE_ONE;

    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            occupancy    <= '0;
            window_ready <= 1'b0;
            release_err  <= 1'b0;
        end else begin
            occupancy    <= occ_next;
            window_ready <= ({1'b0, occ_next} >= window_need) ||
                            (drain_next && (occ_next != '0));
            if (release_at_zero) begin
                release_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/neuron_cache_fill_control.sv
// Writes the column-major pixel stream into the rotating neuron-cache channels
// and back-pressures the stream while every channel holds an unconsumed column.
module neuron_cache_fill_control
    import neuron_cache_pkg::*;
(
    input  logic                               clk,
    input  logic                               layer_reset,
    input  logic                               pixel_valid_i,
    output logic                               pixel_ready_o,
    input  logic [DATA_BIT_WIDTH-1:0]          pixel_data_i,
    input  logic [CACHE_DEPTH_BIT_WIDTH-1:0]   picture_height_i,
    input  logic [PICTURE_WIDTH_BIT_WIDTH-1:0] picture_width_i,
    input  logic [FILTER_WIDTH_BIT_WIDTH-1:0]  filter_width_i,
    input  logic                               column_release_i,
    output logic                               cache_wr_o,
    output logic [CACHE_DEPTH_BIT_WIDTH-1:0]   wr_address_o,
    output logic [CACHE_CHANNELS-1:0]          wr_channel_sel_o,
    output logic [DATA_BIT_WIDTH-1:0]          wr_data_o,
    output logic [OCC_BIT_WIDTH-1:0]           occupancy_o,
    output logic                               window_ready_o,
    output logic                               layer_done_o,
    output logic                               release_err_o
);

    localparam logic [CACHE_DEPTH_BIT_WIDTH-1:0]   ROW_ONE = CACHE_DEPTH_BIT_WIDTH'(1);
    localparam logic [PICTURE_WIDTH_BIT_WIDTH-1:0] COL_ONE = PICTURE_WIDTH_BIT_WIDTH'(1);
    localparam logic [OCC_BIT_WIDTH:0]             OCC_FULL = (OCC_BIT_WIDTH+1)'(CACHE_CHANNELS);

    fill_state_t                        state;
    fill_state_t                        state_next;
    logic [CACHE_DEPTH_BIT_WIDTH-1:0]   row;
    logic [PICTURE_WIDTH_BIT_WIDTH-1:0] column;
    logic [CACHE_CHANNELS-1:0]          write_ptr;
    logic                               accept;
    logic                               column_done;

    assign pixel_ready_o = (state == FILL) && ({1'b0, occupancy_o} < OCC_FULL);
    assign accept        = pixel_valid_i && pixel_ready_o;
    assign column_done   = accept && (row == picture_height_i);

    always_comb begin
        state_next = state;
        unique case (state)
            FILL:    if (column_done && (column == picture_width_i)) state_next = DRAIN;
            DRAIN:   if (occupancy_o == '0) state_next = DONE;
            default: state_next = state;
        endcase
    end

    // Write outputs hold between writes; a reset drops any half-written column.
    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            state            <= FILL;
            row              <= '0;
            column           <= '0;
            write_ptr        <= CHANNEL_SEL_INIT;
            cache_wr_o       <= 1'b0;
            wr_address_o     <= '0;
            wr_channel_sel_o <= CHANNEL_SEL_INIT;
            wr_data_o        <= '0;
            layer_done_o     <= 1'b0;
        end else begin
            state        <= state_next;
            layer_done_o <= (state_next == DONE);
            cache_wr_o   <= accept;
            if (accept) begin
                wr_data_o        <= pixel_data_i;
                wr_address_o     <= row;
                wr_channel_sel_o <= write_ptr;
                row              <= column_done ? '0 : row + ROW_ONE;
            end
            if (column_done) begin
                write_ptr <= rotate_channel(write_ptr);
                column    <= column + COL_ONE;
            end
        end
    end

    neuron_cache_occupancy u_occupancy (
        .clk            (clk),
        .layer_reset    (layer_reset),
        .column_done    (column_done),
        .column_release (column_release_i),
        .drain_next     (state_next == DRAIN),
        .filter_width   (filter_width_i),
        .occupancy      (occupancy_o),
        .window_ready   (window_ready_o),
        .release_err    (release_err_o)
    );

endmodule

// File: tb/tb_neuron_cache_fill_control.sv
// Self-checking bench: vector table, directed corner sequences and randomized
// layers compared against a column-level reference model and write scoreboard.
module tb_neuron_cache_fill_control;
    import neuron_cache_pkg::*;

    logic       clk = 1'b0;
    logic       layer_reset;
    logic       pixel_valid_i;
    logic       pixel_ready_o;
    logic [7:0] pixel_data_i;
    logic [4:0] picture_height_i;
    logic [4:0] picture_width_i;
    logic [2:0] filter_width_i;
    logic       column_release_i;
    logic       cache_wr_o;
    logic [4:0] wr_address_o;
    logic [6:0] wr_channel_sel_o;
    logic [7:0] wr_data_o;
    logic [2:0] occupancy_o;
    logic       window_ready_o;
    logic       layer_done_o;
    logic       release_err_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: columns, channel index, occupancy and layer phase as integers
    int   cfg_h, cfg_w, cfg_fw;
    int   m_row, m_col, m_chan, m_occ, m_mode;
    bit   m_err, m_wr, m_win, m_done;
    int   m_addr, m_data;
    logic [6:0] m_sel;
    int   sb_q[$];
    int   sb_row[7];

    typedef struct {
        bit         valid;
        logic [7:0] data;
        bit         rel;
        bit         exp_wr;
        logic [6:0] exp_sel;
        int         exp_occ;
        bit         exp_ready;
        bit         exp_win;
    } vec_t;
    vec_t vecs[10];

    always #5 clk = ~clk;

    neuron_cache_fill_control dut (
        .clk              (clk),
        .layer_reset      (layer_reset),
        .pixel_valid_i    (pixel_valid_i),
        .pixel_ready_o    (pixel_ready_o),
        .pixel_data_i     (pixel_data_i),
        .picture_height_i (picture_height_i),
        .picture_width_i  (picture_width_i),
        .filter_width_i   (filter_width_i),
        .column_release_i (column_release_i),
        .cache_wr_o       (cache_wr_o),
        .wr_address_o     (wr_address_o),
        .wr_channel_sel_o (wr_channel_sel_o),
        .wr_data_o        (wr_data_o),
        .occupancy_o      (occupancy_o),
        .window_ready_o   (window_ready_o),
        .layer_done_o     (layer_done_o),
        .release_err_o    (release_err_o)
    );

    function automatic logic [6:0] chanOneHot(input int idx);
        logic [6:0] first;
        first = 7'b1000000;
        return first >> idx;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_row = 0; m_col = 0; m_chan = 0; m_occ = 0; m_mode = 0;
        m_err = 0; m_wr = 0; m_win = 0; m_done = 0;
        m_addr = 0; m_data = 0; m_sel = 7'b1000000;
        sb_q.delete();
        for (int k = 0; k < 7; k++) sb_row[k] = 0;
    endtask

    task automatic setConfig(input int h, input int w, input int fw);
        cfg_h = h; cfg_w = w; cfg_fw = fw;
        picture_height_i = h[4:0];
        picture_width_i  = w[4:0];
        filter_width_i   = fw[2:0];
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_wr"}, cache_wr_o, 0);
        checkOutput({tag, "_addr"}, wr_address_o, 0);
        checkOutput({tag, "_data"}, wr_data_o, 0);
        checkOutput({tag, "_sel"}, wr_channel_sel_o, 7'b1000000);
        checkOutput({tag, "_occ"}, occupancy_o, 0);
        checkOutput({tag, "_win"}, window_ready_o, 0);
        checkOutput({tag, "_done"}, layer_done_o, 0);
        checkOutput({tag, "_err"}, release_err_o, 0);
    endtask

    // Called at a falling edge; leaves the bench at the next falling edge.
    task automatic doReset();
        pixel_valid_i    = 1'b0;
        column_release_i = 1'b0;
        pixel_data_i     = 8'h00;
        layer_reset      = 1'b1;
        #1;
        checkResetValues("reset");
        @(negedge clk);
        @(negedge clk);
        layer_reset = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus, checked against the model and the write scoreboard.
    task automatic applyStimulus(input bit valid, input logic [7:0] data, input bit rel);
        bit ready_m, accept, complete;
        int occ_before, mode_before, eff, idx, exp_d;
        pixel_valid_i    = valid;
        pixel_data_i     = data;
        column_release_i = rel;
        #1;
        ready_m = (m_mode == 0) && (m_occ < 7);
        checkOutput("pixel_ready", pixel_ready_o, ready_m);
        accept   = valid && ready_m;
        complete = accept && (m_row == cfg_h);
        @(posedge clk);
        #1;
        occ_before  = m_occ;
        mode_before = m_mode;
        m_wr = accept;
        if (accept) begin
            m_addr = m_row;
            m_sel  = chanOneHot(m_chan);
            m_data = data;
            m_row  = complete ? 0 : m_row + 1;
            sb_q.push_back(data);
        end
        if (complete && !rel) m_occ++;
        else if (rel && !complete) begin
            if (m_occ == 0) m_err = 1;
            else m_occ--;
        end
        if (mode_before == 0 && complete && m_col == cfg_w) m_mode = 1;
        else if (mode_before == 1 && occ_before == 0) m_mode = 2;
        if (complete) begin
            m_col++;
            m_chan = (m_chan + 1) % 7;
        end
        eff    = (cfg_fw > 5) ? 0 : cfg_fw;
        m_win  = (m_occ >= eff + 1) || (m_mode == 1 && m_occ > 0);
        m_done = (m_mode == 2);
        checkOutput("cache_wr", cache_wr_o, m_wr);
        checkOutput("wr_address", wr_address_o, m_addr);
        checkOutput("wr_channel_sel", wr_channel_sel_o, m_sel);
        checkOutput("wr_data", wr_data_o, m_data);
        checkOutput("occupancy", occupancy_o, m_occ);
        checkOutput("window_ready", window_ready_o, m_win);
        checkOutput("layer_done", layer_done_o, m_done);
        checkOutput("release_err", release_err_o, m_err);
        if (cache_wr_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_write", 1, 0);
            end else begin
                exp_d = sb_q.pop_front();
                checkOutput("sb_data", wr_data_o, exp_d);
                idx = -1;
                for (int k = 0; k < 7; k++) if (wr_channel_sel_o == chanOneHot(k)) idx = k;
                if (idx < 0) begin
                    checkOutput("sb_sel_onehot", wr_channel_sel_o, 7'b1000000);
                end else begin
                    checkOutput("sb_address", wr_address_o, sb_row[idx]);
                    sb_row[idx] = (sb_row[idx] == cfg_h) ? 0 : sb_row[idx] + 1;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] cur;
        bit         rel, was_ready;
        int         cyc;

        layer_reset      = 1'b1;
        pixel_valid_i    = 1'b0;
        pixel_data_i     = 8'h00;
        column_release_i = 1'b0;
        setConfig(0, 0, 0);
        modelReset();

        // H=0: every pixel closes a column; fill to 7, wrap, and overlap events
        vecs[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 7'b1000000, 1, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 7'b0100000, 2, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 7'b0010000, 3, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 7'b0001000, 4, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 7'b0000100, 5, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h66, 1'b0, 1'b1, 7'b0000010, 6, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 8'h77, 1'b0, 1'b1, 7'b0000001, 7, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 8'h88, 1'b1, 1'b0, 7'b0000001, 6, 1'b1, 1'b1};
        vecs[8] = '{1'b1, 8'h99, 1'b1, 1'b1, 7'b1000000, 6, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 7'b1000000, 5, 1'b1, 1'b1};

        @(negedge clk);
        setConfig(0, 9, 0);
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].rel);
            checkOutput($sformatf("vec%0d_wr", i), cache_wr_o, vecs[i].exp_wr);
            checkOutput($sformatf("vec%0d_sel", i), wr_channel_sel_o, vecs[i].exp_sel);
            checkOutput($sformatf("vec%0d_occ", i), occupancy_o, vecs[i].exp_occ);
            checkOutput($sformatf("vec%0d_ready", i), pixel_ready_o, vecs[i].exp_ready);
            checkOutput($sformatf("vec%0d_win", i), window_ready_o, vecs[i].exp_win);
        end

        // Release with nothing buffered sets a sticky error
        setConfig(0, 9, 0);
        doReset();
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("rel_zero_err", release_err_o, 1);
        checkOutput("rel_zero_occ", occupancy_o, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rel_zero_err_sticky", release_err_o, 1);

        // H=3, W=2, fw=1: three columns with no release end in DRAIN with 3 held
        setConfig(3, 2, 1);
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 8'hA0 + 8'(i), 1'b0);
            if (i == 3) checkOutput("t1_win_after_col0", window_ready_o, 0);
            if (i == 7) checkOutput("t1_win_after_col1", window_ready_o, 1);
        end
        checkOutput("t1_occ_end", occupancy_o, 3);
        checkOutput("t1_last_sel", wr_channel_sel_o, 7'b0010000);
        checkOutput("t1_last_addr", wr_address_o, 3);
        applyStimulus(1'b1, 8'hEE, 1'b0);
        checkOutput("t1_drain_ready", pixel_ready_o, 0);
        checkOutput("t1_drain_nowrite", cache_wr_o, 0);

        // Drain flush: fw=5 needs 6 columns, but the tail still enables fetching
        setConfig(1, 3, 5);
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 8'h30 + 8'(i), 1'b0);
        checkOutput("drain_occ4", occupancy_o, 4);
        checkOutput("drain_win", window_ready_o, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_occ0", occupancy_o, 0);
        checkOutput("drain_not_done_yet", layer_done_o, 0);
        checkOutput("drain_win_off", window_ready_o, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drain_done", layer_done_o, 1);
        applyStimulus(1'b1, 8'h00, 1'b0);
        checkOutput("done_hold", layer_done_o, 1);

        // Reset in the middle of column 1, then restart from channel 0 row 0
        setConfig(3, 2, 1);
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'h60 + 8'(i), 1'b0);
        checkOutput("mid_pre_sel", wr_channel_sel_o, 7'b0100000);
        pixel_valid_i = 1'b1;
        pixel_data_i  = 8'h7F;
        #2;
        layer_reset = 1'b1;
        #1;
        checkResetValues("mid_async");
        @(negedge clk);
        @(negedge clk);
        layer_reset = 1'b0;
        modelReset();
        applyStimulus(1'b1, 8'h5A, 1'b0);
        checkOutput("restart_sel", wr_channel_sel_o, 7'b1000000);
        checkOutput("restart_addr", wr_address_o, 0);
        checkOutput("restart_data", wr_data_o, 8'h5A);

        // Randomized layers: valid held high, stalls come from random releases
        for (int l = 0; l < 4; l++) begin
            setConfig($urandom_range(0, 31), $urandom_range(0, 12), $urandom_range(0, 7));
            doReset();
            cur = 8'($urandom);
            cyc = 0;
            while (m_mode != 2 && cyc < 8000) begin
                rel       = (m_occ > 0) && ($urandom_range(0, 2) == 0);
                was_ready = (m_mode == 0) && (m_occ < 7);
                applyStimulus(1'b1, cur, rel);
                if (was_ready) cur = 8'($urandom);
                cyc++;
            end
            checkOutput($sformatf("rand%0d_layer_done", l), layer_done_o, 1);
            checkOutput($sformatf("rand%0d_sb_empty", l), sb_q.size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
